// File: rtl/issue_sched.sv
// Issue-stage scheduler: round-robin pick of one ready FUST entry per cycle,
// per-unit occupancy tracking, and issue blocking behind an unresolved branch.
module issue_sched #(
    parameter int NUM_FU = 5,
    parameter int BR_IDX = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NUM_FU-1:0] req,
    input  logic [NUM_FU-1:0] fu_done,
    input  logic              freeze,
    input  logic              branch_resolved,
    input  logic              branch_miss,
    output logic [NUM_FU-1:0] grant,
    output logic              grant_valid,
    output logic [2:0]        grant_idx,
    output logic [NUM_FU-1:0] fu_busy,
    output logic              flush,
    output logic [CNT_W-1:0]  issue_cnt
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT_BR,
        FLUSH
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_next;
    logic [NUM_FU-1:0] elig;
    logic              found;

    // Gating with nRST keeps the combinational grant quiet while reset is held.
    assign elig = req & ~fu_busy & {NUM_FU{(state == ISSUE) && !freeze && nRST}};

    // Two-pass scan: indices at or above the pointer first, then the wrapped ones.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (!found && elig[i] && (PTR_W'(i) >= rr_ptr)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = 3'(i);
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (!found && elig[i] && (PTR_W'(i) < rr_ptr)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = 3'(i);
            end
        end
    end

    assign grant_valid = found;

    always_comb begin
        rr_next = (grant_idx == 3'(NUM_FU - 1)) ? '0 : PTR_W'(grant_idx + 3'd1);
    end

    always_comb begin
        next_state = state;
        case (state)
            ISSUE: begin
                if (grant[BR_IDX]) begin
                    next_state = WAIT_BR;
                end
            end
            WAIT_BR: begin
                if (branch_resolved) begin
                    next_state = branch_miss ? FLUSH : ISSUE;
                end
            end
            FLUSH: begin
                next_state = ISSUE;
            end
            default: begin
                next_state = ISSUE;
            end
        endcase
    end

    // Busy units predate any in-flight branch, so a flush leaves fu_busy alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ISSUE;
            rr_ptr    <= '0;
            fu_busy   <= '0;
            flush     <= 1'b0;
            issue_cnt <= '0;
        end else begin
            state   <= next_state;
            flush   <= (next_state == FLUSH);
            fu_busy <= (fu_busy & ~fu_done) | grant;
            if (grant_valid) begin
                rr_ptr    <= rr_next;
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: hand-computed grants, occupancy, branch
// blocking, freeze and reset behaviour checked with immediate assertions.
module tb_issue_sched;

    logic        CLK;
    logic        nRST;
    logic [4:0]  req;
    logic [4:0]  fu_done;
    logic        freeze;
    logic        branch_resolved;
    logic        branch_miss;
    logic [4:0]  grant;
    logic        grant_valid;
    logic [2:0]  grant_idx;
    logic [4:0]  fu_busy;
    logic        flush;
    logic [15:0] issue_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    issue_sched #(
        .NUM_FU(5),
        .BR_IDX(2),
        .CNT_W (16)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .req            (req),
        .fu_done        (fu_done),
        .freeze         (freeze),
        .branch_resolved(branch_resolved),
        .branch_miss    (branch_miss),
        .grant          (grant),
        .grant_valid    (grant_valid),
        .grant_idx      (grant_idx),
        .fu_busy        (fu_busy),
        .flush          (flush),
        .issue_cnt      (issue_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic apply_stimulus(input logic [4:0] r, input logic [4:0] d,
                                  input logic f, input logic br, input logic bm);
        req             = r;
        fu_done         = d;
        freeze          = f;
        branch_resolved = br;
        branch_miss     = bm;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks the one-hot strobe, its OR and its index against one expectation.
    task automatic check_grant(input string tag, input logic v, input logic [2:0] idx);
        logic [4:0] exp_g;
        exp_g = v ? (5'b00001 << idx) : 5'b00000;
        check_output({tag, ".grant"}, 32'(grant), 32'(exp_g));
        check_output({tag, ".valid"}, 32'(grant_valid), 32'(v));
        check_output({tag, ".idx"}, 32'(grant_idx), v ? 32'(idx) : 32'h0);
    endtask

    initial begin
        nRST = 1'b0;
        apply_stimulus(5'b11111, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("rst", 1'b0, 3'd0);
        check_output("rst.busy", 32'(fu_busy), 32'h0);
        check_output("rst.flush", 32'(flush), 32'h0);
        check_output("rst.cnt", 32'(issue_cnt), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;

        // In-order grants 0,1,2; the branch grant parks the scheduler in WAIT_BR.
        check_grant("seq0", 1'b1, 3'd0);
        tick();
        check_grant("seq1", 1'b1, 3'd1);
        tick();
        check_grant("seq2", 1'b1, 3'd2);
        tick();
        check_grant("seq.waitbr", 1'b0, 3'd0);
        check_output("seq.cnt", 32'(issue_cnt), 32'd3);
        check_output("seq.busy", 32'(fu_busy), 32'h07);
        apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0);
        tick();
        apply_stimulus(5'b00000, 5'b00111, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("clr.busy", 32'(fu_busy), 32'h0);

        // Round-robin wrap: pointer 3 -> 4 -> 0 -> 1.
        apply_stimulus(5'b01000, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("rr3", 1'b1, 3'd3);
        tick();
        apply_stimulus(5'b10001, 5'b01000, 1'b0, 1'b0, 1'b0);
        check_grant("rr4", 1'b1, 3'd4);
        tick();
        apply_stimulus(5'b10001, 5'b10000, 1'b0, 1'b0, 1'b0);
        check_grant("rr0", 1'b1, 3'd0);
        tick();
        apply_stimulus(5'b00000, 5'b00001, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(5'b00011, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("rr.ptr1", 1'b1, 3'd1);
        tick();
        check_output("rr.cnt", 32'(issue_cnt), 32'd7);
        apply_stimulus(5'b00000, 5'b00010, 1'b0, 1'b0, 1'b0);
        tick();

        // Busy/done on unit 0: regrant only the cycle after fu_done.
        apply_stimulus(5'b00001, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("bd.t", 1'b1, 3'd0);
        tick();
        check_grant("bd.t1", 1'b0, 3'd0);
        check_output("bd.busy", 32'(fu_busy), 32'h01);
        tick();
        check_grant("bd.t2", 1'b0, 3'd0);
        apply_stimulus(5'b00001, 5'b00001, 1'b0, 1'b0, 1'b0);
        check_grant("bd.t3", 1'b0, 3'd0);
        tick();
        apply_stimulus(5'b00001, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("bd.t4", 1'b1, 3'd0);
        tick();
        apply_stimulus(5'b00000, 5'b00001, 1'b0, 1'b0, 1'b0);
        tick();

        // Branch miss: resolve at t+2, flush at t+3, grants resume at t+4.
        apply_stimulus(5'b00100, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("bm.t", 1'b1, 3'd2);
        tick();
        apply_stimulus(5'b11011, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("bm.t1", 1'b0, 3'd0);
        check_output("bm.t1.flush", 32'(flush), 32'h0);
        tick();
        apply_stimulus(5'b11011, 5'b00000, 1'b0, 1'b1, 1'b1);
        check_grant("bm.t2", 1'b0, 3'd0);
        check_output("bm.t2.flush", 32'(flush), 32'h0);
        tick();
        apply_stimulus(5'b11011, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("bm.t3", 1'b0, 3'd0);
        check_output("bm.t3.flush", 32'(flush), 32'h1);
        check_output("bm.t3.busy", 32'(fu_busy), 32'h04);
        tick();
        check_grant("bm.t4", 1'b1, 3'd3);
        check_output("bm.t4.flush", 32'(flush), 32'h0);
        tick();
        apply_stimulus(5'b00000, 5'b01100, 1'b0, 1'b0, 1'b0);
        tick();

        // Branch hit: resolve at t+2, grant resumes at t+3.
        apply_stimulus(5'b00100, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("bh.t", 1'b1, 3'd2);
        tick();
        apply_stimulus(5'b01000, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("bh.t1", 1'b0, 3'd0);
        tick();
        apply_stimulus(5'b01000, 5'b00000, 1'b0, 1'b1, 1'b0);
        check_grant("bh.t2", 1'b0, 3'd0);
        tick();
        apply_stimulus(5'b01000, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("bh.t3", 1'b1, 3'd3);
        check_output("bh.t3.flush", 32'(flush), 32'h0);
        tick();
        apply_stimulus(5'b00000, 5'b01100, 1'b0, 1'b0, 1'b0);
        tick();

        // A resolution in the branch's own grant cycle must be ignored.
        apply_stimulus(5'b00100, 5'b00000, 1'b0, 1'b1, 1'b1);
        check_grant("bs.t", 1'b1, 3'd2);
        tick();
        apply_stimulus(5'b01000, 5'b00000, 1'b0, 1'b1, 1'b0);
        check_grant("bs.t1", 1'b0, 3'd0);
        check_output("bs.t1.flush", 32'(flush), 32'h0);
        tick();
        apply_stimulus(5'b01000, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("bs.t2", 1'b1, 3'd3);
        tick();
        check_output("bs.cnt", 32'(issue_cnt), 32'd15);
        apply_stimulus(5'b00000, 5'b01100, 1'b0, 1'b0, 1'b0);
        tick();

        // Freeze: no grants, counter held, fu_done still clears busy.
        apply_stimulus(5'b01000, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("fz.pre", 1'b1, 3'd3);
        tick();
        apply_stimulus(5'b00010, 5'b00000, 1'b1, 1'b0, 1'b0);
        check_grant("fz.c1", 1'b0, 3'd0);
        tick();
        apply_stimulus(5'b00010, 5'b01000, 1'b1, 1'b0, 1'b0);
        check_grant("fz.c2", 1'b0, 3'd0);
        tick();
        apply_stimulus(5'b00010, 5'b00000, 1'b1, 1'b0, 1'b0);
        check_grant("fz.c3", 1'b0, 3'd0);
        check_output("fz.busy", 32'(fu_busy), 32'h0);
        check_output("fz.cnt", 32'(issue_cnt), 32'd16);
        tick();
        apply_stimulus(5'b00010, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("fz.post", 1'b1, 3'd1);
        tick();
        check_output("fz.cnt2", 32'(issue_cnt), 32'd17);

        // Reset while waiting on a branch with units 4 and 2 busy.
        apply_stimulus(5'b10000, 5'b00010, 1'b0, 1'b0, 1'b0);
        check_grant("mr.g4", 1'b1, 3'd4);
        tick();
        apply_stimulus(5'b00100, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("mr.g2", 1'b1, 3'd2);
        tick();
        apply_stimulus(5'b11111, 5'b00000, 1'b0, 1'b0, 1'b0);
        check_grant("mr.wait", 1'b0, 3'd0);
        check_output("mr.busy", 32'(fu_busy), 32'h14);
        check_output("mr.cnt", 32'(issue_cnt), 32'd19);
        nRST = 1'b0;
        #1;
        check_grant("mr.rst", 1'b0, 3'd0);
        check_output("mr.rst.busy", 32'(fu_busy), 32'h0);
        check_output("mr.rst.flush", 32'(flush), 32'h0);
        check_output("mr.rst.cnt", 32'(issue_cnt), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check_grant("mr.rel", 1'b1, 3'd0);
        tick();
        check_output("mr.rel.cnt", 32'(issue_cnt), 32'd1);
        check_output("mr.rel.flush", 32'(flush), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
